// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace buffer: ebreak encoding, counter
// widths and the packed layout of one trace entry (cycle stamp appended by the user).
package trace_pkg;
    localparam int PC_W   = 64;
    localparam int INST_W = 32;
    localparam int SEQ_W  = 64;

    localparam logic [INST_W-1:0] EBREAK_INST = 32'h0010_0073;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic [SEQ_W-1:0]  seq;
    } trace_entry_t;

    localparam int ENTRY_BASE_W = $bits(trace_entry_t);
endpackage

// File: rtl/commit_trace_buf_if.sv
// Trace output channel: head entry presented with valid, consumer answers with ready.
interface commit_trace_buf_if #(
    parameter int TS_W = 32
);
    import trace_pkg::*;

    logic              tr_valid;
    logic              tr_ready;
    logic [PC_W-1:0]   tr_pc;
    logic [INST_W-1:0] tr_inst;
    logic [SEQ_W-1:0]  tr_seq;
    logic [TS_W-1:0]   tr_cycle;

    modport master (
        output tr_valid, tr_pc, tr_inst, tr_seq, tr_cycle,
        input  tr_ready
    );

    modport slave (
        input  tr_valid, tr_pc, tr_inst, tr_seq, tr_cycle,
        output tr_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO on a flat register array.
// The caller must not push when full unless it pops in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Storage is never reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Extra pointer MSB tells a full wrap apart from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];
endmodule

// File: rtl/commit_trace_buf.sv
// Captures retired instructions with sequence number and cycle stamp into a FIFO
// for a trace consumer; drops (and counts) on overflow, halts capture after ebreak.
module commit_trace_buf
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TS_W  = 32,
    parameter int DC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cm_valid,
    input  logic [PC_W-1:0]         cm_pc,
    input  logic [INST_W-1:0]       cm_inst,
    input  logic                    resume,
    commit_trace_buf_if.master      tr,
    output logic [$clog2(DEPTH):0]  level,
    output logic [DC_W-1:0]         drop_cnt,
    output logic                    halted
);
    localparam int EW = ENTRY_BASE_W + TS_W;

    localparam logic [0:0] ST_CAPTURE = 1'b0;
    localparam logic [0:0] ST_HALT    = 1'b1;

    localparam logic [SEQ_W-1:0] SEQ_ONE = {{(SEQ_W-1){1'b0}}, 1'b1};
    localparam logic [TS_W-1:0]  CYC_ONE = {{(TS_W-1){1'b0}}, 1'b1};
    localparam logic [DC_W-1:0]  DC_ONE  = {{(DC_W-1){1'b0}}, 1'b1};

    logic [0:0]       state_q, state_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [TS_W-1:0]  cyc_q, cyc_d;
    logic [DC_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic         accept, push, pop, drop;
    logic         fifo_full, fifo_empty;
    logic [EW-1:0] fifo_wdata, fifo_rdata;
    trace_entry_t wr_entry, head;
    logic [TS_W-1:0] head_cyc;

    assign accept = cm_valid && (state_q == ST_CAPTURE);
    assign pop    = !fifo_empty && tr.tr_ready;
    // A pop in the same cycle frees a slot, so a full buffer still takes the commit.
    assign push   = accept && (!fifo_full || pop);
    assign drop   = accept && fifo_full && !pop;

    assign wr_entry   = '{pc: cm_pc, inst: cm_inst, seq: seq_q};
    assign fifo_wdata = {wr_entry, cyc_q};

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_comb begin
        cyc_d      = cyc_q + CYC_ONE;
        seq_d      = accept ? seq_q + SEQ_ONE : seq_q;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DC_ONE;
        end
        state_d = state_q;
        case (state_q)
            ST_CAPTURE: if (accept && (cm_inst == EBREAK_INST)) state_d = ST_HALT;
            ST_HALT:    if (resume) state_d = ST_CAPTURE;
            default:    state_d = ST_CAPTURE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CAPTURE;
            seq_q      <= '0;
            cyc_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            cyc_q      <= cyc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign head     = trace_entry_t'(fifo_rdata[EW-1:TS_W]);
    assign head_cyc = fifo_rdata[TS_W-1:0];

    // Head fields are forced to zero so stale storage never leaks out.
    assign tr.tr_valid = !fifo_empty;
    assign tr.tr_pc    = fifo_empty ? '0 : head.pc;
    assign tr.tr_inst  = fifo_empty ? '0 : head.inst;
    assign tr.tr_seq   = fifo_empty ? '0 : head.seq;
    assign tr.tr_cycle = fifo_empty ? '0 : head_cyc;

    assign drop_cnt = drop_cnt_q;
    assign halted   = (state_q == ST_HALT);
endmodule

// File: tb/tb_commit_trace_buf.sv
// Scoreboard bench for commit_trace_buf: a reference model queues expected entries
// as commits are driven and pops them as the consumer accepts the head.
module tb_commit_trace_buf;
    import trace_pkg::*;

    localparam int DEPTH = 16;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] seq;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        cm_valid = 1'b0;
    logic [63:0] cm_pc = '0;
    logic [31:0] cm_inst = '0;
    logic        resume = 1'b0;
    logic [4:0]  level;
    logic [31:0] drop_cnt;
    logic        halted;

    logic        s_cm_valid = 1'b0;
    logic [63:0] s_cm_pc = 64'h1000;
    logic [31:0] s_cm_inst = 32'h13;
    logic        s_resume = 1'b0;
    logic [1:0]  s_level;
    logic [1:0]  s_drop_cnt;
    logic        s_halted;

    commit_trace_buf_if #(.TS_W(32)) tr_if ();
    commit_trace_buf_if #(.TS_W(4))  s_if ();

    commit_trace_buf #(.DEPTH(DEPTH), .TS_W(32), .DC_W(32)) dut (
        .clk (clk), .rst (rst), .cm_valid (cm_valid), .cm_pc (cm_pc),
        .cm_inst (cm_inst), .resume (resume), .tr (tr_if),
        .level (level), .drop_cnt (drop_cnt), .halted (halted)
    );

    commit_trace_buf #(.DEPTH(2), .TS_W(4), .DC_W(2)) dut_small (
        .clk (clk), .rst (rst), .cm_valid (s_cm_valid), .cm_pc (s_cm_pc),
        .cm_inst (s_cm_inst), .resume (s_resume), .tr (s_if),
        .level (s_level), .drop_cnt (s_drop_cnt), .halted (s_halted)
    );

    int checks = 0;
    int errors = 0;

    exp_t        sb_q[$];
    int          cnt_m = 0;
    bit          halt_m = 1'b0;
    logic [63:0] seq_m = '0;
    logic [31:0] cyc_m = '0;
    logic [31:0] drop_m = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, compare current outputs
    // against the model, advance the model, then wait for the next falling edge.
    task automatic step(input bit r, input bit cv, input logic [63:0] pc,
                        input logic [31:0] inst, input bit rdy, input bit res);
        exp_t e;
        bit   pop, accept, full;
        rst = r; cm_valid = cv; cm_pc = pc; cm_inst = inst; resume = res;
        tr_if.tr_ready = rdy;
        if (r) begin
            sb_q.delete();
            cnt_m = 0; halt_m = 1'b0; seq_m = '0; cyc_m = '0; drop_m = '0;
        end else begin
            chk("tr_valid", 64'(tr_if.tr_valid), 64'(cnt_m > 0));
            chk("level", 64'(level), 64'(cnt_m));
            chk("drop_cnt", 64'(drop_cnt), 64'(drop_m));
            chk("halted", 64'(halted), 64'(halt_m));
            if (cnt_m == 0) begin
                chk("idle_pc", tr_if.tr_pc, 64'h0);
                chk("idle_seq", tr_if.tr_seq, 64'h0);
            end
            pop    = rdy && (cnt_m > 0);
            accept = cv && !halt_m;
            full   = (cnt_m == DEPTH);
            if (pop) begin
                e = sb_q.pop_front();
                chk("head_pc", tr_if.tr_pc, e.pc);
                chk("head_inst", 64'(tr_if.tr_inst), 64'(e.inst));
                chk("head_seq", tr_if.tr_seq, e.seq);
                chk("head_cycle", 64'(tr_if.tr_cycle), 64'(e.cyc));
                cnt_m--;
            end
            if (accept && (!full || pop)) begin
                sb_q.push_back('{pc: pc, inst: inst, seq: seq_m, cyc: cyc_m});
                cnt_m++;
            end
            if (accept && full && !pop) drop_m++;
            if (accept) seq_m++;
            if (!halt_m && accept && inst == EBREAK_INST) halt_m = 1'b1;
            else if (halt_m && res) halt_m = 1'b0;
            cyc_m++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'h0, 32'h0, rdy, 1'b0);
    endtask

    task automatic commit(input logic [63:0] pc, input bit rdy);
        step(1'b0, 1'b1, pc, 32'h0000_0013, rdy, 1'b0);
    endtask

    initial begin
        tr_if.tr_ready = 1'b0;
        s_if.tr_ready  = 1'b0;
        @(negedge clk);

        // T1: reset state and three spaced commits drained immediately
        step(1'b1, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        chk("rst_valid", 64'(tr_if.tr_valid), 64'h0);
        chk("rst_level", 64'(level), 64'h0);
        chk("rst_drop", 64'(drop_cnt), 64'h0);
        chk("rst_halted", 64'(halted), 64'h0);
        chk("rst_cycle", 64'(tr_if.tr_cycle), 64'h0);
        for (int k = 0; k < 13; k++) begin
            if (k == 5)      commit(64'h8000_0000, 1'b1);
            else if (k == 6) commit(64'h8000_0004, 1'b1);
            else if (k == 9) begin
                commit(64'h8000_0008, 1'b1);
                chk("t1_seq2", tr_if.tr_seq, 64'd2);
                chk("t1_cyc9", 64'(tr_if.tr_cycle), 64'd9);
            end
            else idle(1, 1'b1);
        end
        chk("t1_level0", 64'(level), 64'h0);

        // T2: overflow with a stalled consumer, then drain
        for (int i = 0; i < 20; i++) commit(64'h8000_1000 + 64'(4 * i), 1'b0);
        chk("t2_level", 64'(level), 64'd16);
        chk("t2_drops", 64'(drop_cnt), 64'd4);
        chk("t2_head_seq", tr_if.tr_seq, 64'd3);
        idle(16, 1'b1);
        commit(64'h8000_2000, 1'b0);
        chk("t2_seq_after_gap", tr_if.tr_seq, 64'd23);
        idle(2, 1'b1);

        // T3: full buffer with simultaneous push and pop
        for (int i = 0; i < 16; i++) commit(64'h8000_3000 + 64'(4 * i), 1'b0);
        chk("t3_full", 64'(level), 64'd16);
        for (int i = 0; i < 8; i++) commit(64'h8000_4000 + 64'(4 * i), 1'b1);
        chk("t3_level", 64'(level), 64'd16);
        chk("t3_drops", 64'(drop_cnt), 64'd4);
        idle(18, 1'b1);

        // T4: ebreak halts capture; resume with a coincident commit
        step(1'b1, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) commit(64'h8000_0000 + 64'(4 * i), 1'b1);
        step(1'b0, 1'b1, 64'h8000_0010, EBREAK_INST, 1'b1, 1'b0);
        chk("t4_halted", 64'(halted), 64'h1);
        chk("t4_ebreak_inst", 64'(tr_if.tr_inst), 64'(EBREAK_INST));
        for (int i = 0; i < 5; i++) commit(64'h8000_0020 + 64'(4 * i), 1'b1);
        chk("t4_still_halted", 64'(halted), 64'h1);
        step(1'b0, 1'b1, 64'h8000_0040, 32'h13, 1'b1, 1'b1);
        chk("t4_resumed", 64'(halted), 64'h0);
        commit(64'h8000_0044, 1'b1);
        chk("t4_seq_resume", tr_if.tr_seq, 64'd5);
        idle(2, 1'b1);

        // T5: reset while holding entries and halted
        for (int i = 0; i < 6; i++) commit(64'h8000_5000 + 64'(4 * i), 1'b0);
        step(1'b0, 1'b1, 64'h8000_5018, EBREAK_INST, 1'b0, 1'b0);
        chk("t5_level7", 64'(level), 64'd7);
        chk("t5_halted", 64'(halted), 64'h1);
        step(1'b1, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        chk("t5_valid", 64'(tr_if.tr_valid), 64'h0);
        chk("t5_level", 64'(level), 64'h0);
        chk("t5_halted0", 64'(halted), 64'h0);
        idle(3, 1'b0);
        commit(64'h8000_6000, 1'b0);
        chk("t5_seq0", tr_if.tr_seq, 64'd0);
        chk("t5_cyc3", 64'(tr_if.tr_cycle), 64'd3);
        idle(2, 1'b1);

        // T6: narrow stamp wraps, narrow drop counter saturates
        step(1'b1, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        chk("t6_s_level0", 64'(s_level), 64'h0);
        idle(17, 1'b0);
        s_cm_valid = 1'b1;
        idle(7, 1'b0);
        s_cm_valid = 1'b0;
        chk("t6_s_level", 64'(s_level), 64'd2);
        chk("t6_s_drops", 64'(s_drop_cnt), 64'd3);
        chk("t6_s_cycle", 64'(s_if.tr_cycle), 64'd1);
        chk("t6_s_seq", s_if.tr_seq, 64'd0);
        s_if.tr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_if.tr_ready = 1'b0;
        chk("t6_s_cycle2", 64'(s_if.tr_cycle), 64'd2);
        chk("t6_s_seq1", s_if.tr_seq, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
